// File: rtl/vpipe_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: operation encoding
// and the carry-in rule applied before the first segment.
package vpipe_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // SUB is in0 + ~in1 + !cin, so the chain's carry-in is the inverted borrow.
    function automatic logic eff_carry(input op_e op, input logic cin);
        return (op == OP_SUB) ? !cin : cin;
    endfunction

endpackage

// File: rtl/vpipe_adder_stage.sv
// One carry-chain segment: seg-bit add with carry in and carry out.
module vpipe_adder_stage #(
    parameter int seg = 16
) (
    input  logic [seg-1:0] a,
    input  logic [seg-1:0] b,
    input  logic           cin,
    output logic [seg-1:0] sum,
    output logic           cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{seg{1'b0}}, cin};

endmodule

// File: rtl/vpipe_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into nstages segments,
// one per register stage, with elastic val/rdy on both sides.
module vpipe_adder
    import vpipe_adder_pkg::*;
#(
    parameter int nbits   = 32,
    parameter int nstages = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic             in_op,
    input  logic [nbits-1:0] in_in0,
    input  logic [nbits-1:0] in_in1,
    input  logic             in_cin,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [nbits-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int seg = nbits / nstages;

    if ((nstages < 1) || (nbits % nstages != 0)) begin : g_param_check
        $error("vpipe_adder: nbits must be a multiple of nstages and nstages >= 1");
    end

    // Stage payload; declared here because its width follows nbits.
    // b holds the already-inverted operand for SUB.
    typedef struct packed {
        logic             valid;
        op_e              op;
        logic [nbits-1:0] a;
        logic [nbits-1:0] b;
        logic [nbits-1:0] sum;
        logic             carry;
        logic             ovf;
    } stage_t;

    stage_t             pipe_q [nstages];
    logic [nstages-1:0] v;
    logic [nstages-1:0] load;

    // Ready ripples from the output back to the input in one cycle.
    always_comb begin
        logic adv;
        v    = '0;
        load = '0;
        adv  = out_rdy;
        for (int k = nstages - 1; k >= 0; k--) begin
            v[k]    = pipe_q[k].valid;
            load[k] = !v[k] || adv;
            adv     = load[k];
        end
    end

    assign in_rdy = load[0];

    for (genvar k = 0; k < nstages; k++) begin : g_stage
        stage_t         src;
        stage_t         nxt;
        logic [seg-1:0] seg_sum;
        logic           seg_cout;

        if (k == 0) begin : g_head
            always_comb begin
                src       = '0;
                src.valid = in_val;
                src.op    = op_e'(in_op);
                src.a     = in_in0;
                src.b     = (op_e'(in_op) == OP_SUB) ? ~in_in1 : in_in1;
                src.carry = eff_carry(op_e'(in_op), in_cin);
            end
        end else begin : g_body
            assign src = pipe_q[k-1];
        end

        vpipe_adder_stage #(
            .seg (seg)
        ) u_seg (
            .a    (src.a[k*seg +: seg]),
            .b    (src.b[k*seg +: seg]),
            .cin  (src.carry),
            .sum  (seg_sum),
            .cout (seg_cout)
        );

        // ovf is only meaningful once the top segment is summed; the last
        // stage overwrites whatever earlier stages left in it.
        always_comb begin
            nxt                     = src;
            nxt.sum[k*seg +: seg]   = seg_sum;
            nxt.carry               = seg_cout;
            nxt.ovf                 = (src.a[nbits-1] == src.b[nbits-1]) &&
                                      (seg_sum[seg-1] != src.a[nbits-1]);
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                pipe_q[k] <= '0;
            end else if (load[k]) begin
                if (src.valid) begin
                    pipe_q[k] <= nxt;
                end else begin
                    pipe_q[k].valid <= 1'b0;
                end
            end
        end
    end

    assign out_val  = pipe_q[nstages-1].valid;
    assign out_sum  = pipe_q[nstages-1].sum;
    assign out_cout = pipe_q[nstages-1].carry;
    assign out_ovf  = pipe_q[nstages-1].ovf;

    logic unused_tail;
    assign unused_tail = ^{pipe_q[nstages-1].op, pipe_q[nstages-1].a, pipe_q[nstages-1].b};

endmodule

// File: tb/tb_vpipe_adder.sv
// Scoreboard bench for vpipe_adder: a 32-bit/2-stage and a 64-bit/4-stage instance.
module tb_vpipe_adder;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        a_in_val, a_in_rdy, a_in_op, a_in_cin;
    logic        a_out_val, a_out_rdy, a_out_cout, a_out_ovf;
    logic [31:0] a_in_in0, a_in_in1, a_out_sum;

    logic        b_in_val, b_in_rdy, b_in_op, b_in_cin;
    logic        b_out_val, b_out_rdy, b_out_cout, b_out_ovf;
    logic [63:0] b_in_in0, b_in_in1, b_out_sum;

    // expected {cout, ovf, sum[63:0]}
    logic [65:0] exp32_q[$];
    logic [65:0] exp64_q[$];
    int          lat32_q[$];
    int          lat64_q[$];

    logic        hold_arm = 1'b0;
    logic [33:0] hold_val;
    bit          rnd_done;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vpipe_adder #(.nbits(32), .nstages(2)) dut32 (
        .clk(clk), .reset(reset),
        .in_val(a_in_val), .in_rdy(a_in_rdy), .in_op(a_in_op),
        .in_in0(a_in_in0), .in_in1(a_in_in1), .in_cin(a_in_cin),
        .out_val(a_out_val), .out_rdy(a_out_rdy), .out_sum(a_out_sum),
        .out_cout(a_out_cout), .out_ovf(a_out_ovf)
    );

    vpipe_adder #(.nbits(64), .nstages(4)) dut64 (
        .clk(clk), .reset(reset),
        .in_val(b_in_val), .in_rdy(b_in_rdy), .in_op(b_in_op),
        .in_in0(b_in_in0), .in_in1(b_in_in1), .in_cin(b_in_cin),
        .out_val(b_out_val), .out_rdy(b_out_rdy), .out_sum(b_out_sum),
        .out_cout(b_out_cout), .out_ovf(b_out_ovf)
    );

    // ---------------- reference model ----------------
    // Plain integer arithmetic: unsigned result for sum/cout, signed result
    // range for overflow. For SUB, cin acts as a borrow.
    function automatic logic [65:0] model(input int w, input logic op,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic cin);
        logic [65:0]        ua, ub, ur, uc;
        logic signed [67:0] sa, sb, sr, sc, smax, smin;
        logic [63:0]        mask;
        logic               co, ov;
        ua = {2'b00, a};
        ub = {2'b00, b};
        uc = {65'd0, cin};
        sa = $signed({4'b0000, a});
        sb = $signed({4'b0000, b});
        sc = $signed({67'd0, cin});
        if (a[w-1]) sa = sa - (68'sd1 <<< w);
        if (b[w-1]) sb = sb - (68'sd1 <<< w);
        if (op == 1'b0) begin
            ur = ua + ub + uc;
            co = ur[w];
            sr = sa + sb + sc;
        end else begin
            ur = ua - ub - uc;
            co = (ua >= ub + uc);
            sr = sa - sb - sc;
        end
        smax = (68'sd1 <<< (w - 1)) - 68'sd1;
        smin = -(68'sd1 <<< (w - 1));
        ov   = (sr > smax) || (sr < smin);
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        return {co, ov, ur[63:0] & mask};
    endfunction

    task automatic chk(input string name, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at posedge+1; returns at posedge+1 right after the transfer edge.
    task automatic send32(input logic op, input logic [31:0] x, input logic [31:0] y,
                          input logic c, input bit lat);
        int n = 0;
        a_in_val = 1'b1; a_in_op = op; a_in_in0 = x; a_in_in1 = y; a_in_cin = c;
        @(negedge clk);
        while (!a_in_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!a_in_rdy) begin
            checks++; errors++;
            $display("FAIL send32_timeout in_rdy stayed 0 for %0d cycles", n);
        end else begin
            exp32_q.push_back(model(32, op, {32'd0, x}, {32'd0, y}, c));
            lat32_q.push_back(lat ? cyc : -1);
        end
        @(posedge clk); #1;
        a_in_val = 1'b0;
    endtask

    task automatic send64(input logic op, input logic [63:0] x, input logic [63:0] y,
                          input logic c, input bit lat);
        int n = 0;
        b_in_val = 1'b1; b_in_op = op; b_in_in0 = x; b_in_in1 = y; b_in_cin = c;
        @(negedge clk);
        while (!b_in_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!b_in_rdy) begin
            checks++; errors++;
            $display("FAIL send64_timeout in_rdy stayed 0 for %0d cycles", n);
        end else begin
            exp64_q.push_back(model(64, op, x, y, c));
            lat64_q.push_back(lat ? cyc : -1);
        end
        @(posedge clk); #1;
        b_in_val = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp32_q.size() != 0 || exp64_q.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_queues_empty", 66'(exp32_q.size() + exp64_q.size()), 66'd0);
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        chk({name, "_out32"}, {31'd0, a_out_val, a_out_cout, a_out_ovf, a_out_sum}, 66'd0);
        chk({name, "_out64"}, {b_out_val, b_out_cout, b_out_ovf, b_out_sum[62:0]}, 66'd0);
        chk({name, "_in_rdy"}, {64'd0, a_in_rdy, b_in_rdy}, 66'd3);
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 4))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (reset && a_out_val && a_out_rdy) begin
            if (exp32_q.size() == 0) begin
                chk("unexpected_out32", {a_out_cout, a_out_ovf, 32'd0, a_out_sum}, 66'h3_FFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [65:0] e;
                int          t;
                e = exp32_q.pop_front();
                t = lat32_q.pop_front();
                chk("result32", {a_out_cout, a_out_ovf, 32'd0, a_out_sum}, e);
                if (t >= 0) chk("latency32", 66'(cyc - t), 66'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && b_out_val && b_out_rdy) begin
            if (exp64_q.size() == 0) begin
                chk("unexpected_out64", {b_out_cout, b_out_ovf, b_out_sum}, 66'h3_FFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [65:0] e;
                int          t;
                e = exp64_q.pop_front();
                t = lat64_q.pop_front();
                chk("result64", {b_out_cout, b_out_ovf, b_out_sum}, e);
                if (t >= 0) chk("latency64", 66'(cyc - t), 66'd4);
            end
        end
    end

    // A stalled response must stay put until it is taken.
    always @(negedge clk) begin
        if (!reset) begin
            hold_arm = 1'b0;
        end else begin
            if (hold_arm)
                chk("hold_stable32", {31'd0, a_out_val, a_out_cout, a_out_ovf, a_out_sum},
                    {31'd0, 1'b1, hold_val});
            hold_arm = a_out_val && !a_out_rdy;
            hold_val = {a_out_cout, a_out_ovf, a_out_sum};
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        a_in_val = 0; a_in_op = 0; a_in_in0 = '0; a_in_in1 = '0; a_in_cin = 0; a_out_rdy = 1;
        b_in_val = 0; b_in_op = 0; b_in_in0 = '0; b_in_in1 = '0; b_in_cin = 0; b_out_rdy = 1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        check_idle("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // directed 32-bit cases
        send32(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1);
        send32(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1);
        send32(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 1);
        send32(1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1);
        send32(1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1, 1);
        repeat (4) @(posedge clk); #1;

        // back-to-back stream i + 2i
        for (int i = 0; i < 8; i++) send32(1'b0, 32'(i), 32'(2 * i), 1'b0, 1);
        drain();

        // random ops with a randomly stalling consumer
        rnd_done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send32(1'($urandom_range(0, 1)), pick32(), pick32(), 1'($urandom_range(0, 1)), 0);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    a_out_rdy = ($urandom_range(0, 3) != 0);
                end
            end
        join
        a_out_rdy = 1'b1;
        drain();

        // fill with consumer stalled, then release
        a_out_rdy = 1'b0;
        send32(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 0);
        send32(1'b1, 32'h0000_0010, 32'h0000_0020, 1'b1, 0);
        chk("full_in_rdy_low", {65'd0, a_in_rdy}, 66'd0);
        fork
            send32(1'b0, 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 0);
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("stalled_in_rdy_low", {64'd0, a_in_rdy, a_out_val}, 66'd1);
                @(posedge clk); #1;
                a_out_rdy = 1'b1;
            end
        join
        drain();

        // reset with two operations in flight; they must vanish
        send32(1'b0, 32'h0000_00AA, 32'h0000_0055, 1'b0, 0);
        send32(1'b0, 32'h0000_0100, 32'h0000_0200, 1'b0, 0);
        reset = 1'b0;
        exp32_q.delete();
        lat32_q.delete();
        @(posedge clk);
        check_idle("mid_reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_in_rdy", {64'd0, a_in_rdy, a_out_val}, 66'd2);
        repeat (6) @(posedge clk); #1;
        send32(1'b0, 32'h0000_0003, 32'h0000_0004, 1'b0, 1);
        drain();

        // 64-bit, 4-stage instance: carry across segment boundaries
        send64(1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1);
        send64(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1);
        send64(1'b1, 64'h0, 64'h1, 1'b0, 1);
        send64(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1);
        send64(1'b1, 64'h8000_0000_0000_0000, 64'h1, 1'b0, 1);
        for (int i = 0; i < 12; i++)
            send64(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                   1'($urandom_range(0, 1)), 1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vpipe_adder.md
Name: vpipe_adder

Overview:
- Parametrised, pipelined add/subtract unit with carry-in, carry-out and signed-overflow flags.
- The carry chain is split into nstages equal segments, one per pipeline stage, so wide adders meet timing.
- Elastic val/rdy interfaces on both sides allow the unit to sit between any latency-insensitive producer and consumer in the datapath.

Parameters:
- nbits, 32, operand and result width; must be divisible by nstages.
- nstages, 2, number of pipeline stages, >= 1. Segment width is seg = nbits/nstages.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; reset == 0 at a rising edge resets the block.
- in_val  input  1  request valid.
- in_rdy  output  1  request ready.
- in_op  input  1  0 = ADD, 1 = SUB.
- in_in0  input  nbits  operand A.
- in_in1  input  nbits  operand B.
- in_cin  input  1  carry-in for ADD, borrow-in for SUB.
- out_val  output  1  response valid.
- out_rdy  input  1  response ready.
- out_sum  output  nbits  result.
- out_cout  output  1  carry-out; for SUB, 1 = no borrow.
- out_ovf  output  1  signed two's-complement overflow.

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where val && rdy; data is sampled only on a transfer.
- Arithmetic:
  - ADD: {cout, sum} = in0 + in1 + cin, computed at nbits+1 width.
  - SUB: computed as in0 + ~in1 + !cin, so cout = 1 means no borrow.
  - ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' is the inverted operand for SUB.
- Stage k (0..nstages-1):
  - Adds segment k of A and B' plus the carry registered from stage k-1; stage 0 uses the effective cin.
  - Registers the partial sum segment and its carry.
  - Carries the not-yet-summed upper operand segments and the lower result segments forward unchanged.
- Latency: exactly nstages cycles from input transfer to out_val when not stalled. Throughput is 1 per cycle.
- Stage valid bits v[0..nstages-1]:
  - Stage k loads when !v[k] || advance[k]; advance[last] = out_rdy.
  - in_rdy = !v[0] || advance[0]. The ready chain is combinational across stages; no combinational path from in_val to out_val.
- out_val = v[nstages-1]. out_sum, out_cout and out_ovf are registered outputs of the last stage and stay stable while out_val && !out_rdy.
- Full pipeline with out_rdy = 0: in_rdy = 0 and no stage data changes.
- Empty pipeline: in_rdy = 1 and out_val = 0.
- Simultaneous enqueue and dequeue in the full state: the pipeline advances with no bubble.
- Wrap-around: sum wraps modulo 2^nbits; overflow is reported only via cout/ovf.
- Reset:
  - All v[k] = 0; out_val = 0; out_sum = 0; out_cout = 0; out_ovf = 0.
  - Reset mid-operation discards all in-flight operations; in_rdy = 1 on the first cycle after reset deasserts.
- nstages == 1: a single registered stage that computes the full-width sum in one cycle.

Decomposition:
- Shared package vpipe_adder_pkg:
  - op enum (OP_ADD = 0, OP_SUB = 1).
  - A stage payload struct type holding valid, op, partial sum, carry, and remaining operand bits, parametrised by width.
- Sub-module vpipe_adder_stage (parameter seg): one segment adder, instantiated nstages times by a generate loop. The top level holds the handshake/valid logic.

Test Plan:
- nbits=32, nstages=2, out_rdy=1: ADD 0xFFFFFFFF + 0x00000001 + cin=0 -> after 2 cycles, sum=0x00000000, cout=1, ovf=0.
- SUB 0x80000000 - 0x00000001, cin=0 -> sum=0x7FFFFFFF, cout=1, ovf=1; SUB 0x5 - 0x7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Back-to-back stream of 8 ADDs (i + 2i) with out_rdy=1 -> 8 consecutive out_val cycles starting at cycle 2, in order, sums 3i.
- Fill the pipeline with out_rdy=0 -> in_rdy drops after 2 accepted transfers and outputs hold stable; raise out_rdy -> results drain in order with no loss or duplicate.
- Assert reset=0 with 2 operations in flight -> out_val=0 and all outputs 0 next cycle; the discarded results never appear.
- nbits=64, nstages=4: ADD 0x00000000FFFFFFFF + 0x1 -> sum=0x0000000100000000 after 4 cycles, confirming the carry crosses segment boundaries.
